// File: rtl/simmem_port_if.sv
// Request/acknowledge bus of the simulation memory port.
// The master issues accesses and the slave (the memory) answers with busy/ack/err.
interface simmem_port_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LANES = DATA_W / 8;

    logic              req;
    logic              nRW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  nBE;
    logic              busy;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, nRW, addr, wdata, nBE,
        input  busy, ack, rdata, err
    );

    modport slave (
        input  req, nRW, addr, wdata, nBE,
        output busy, ack, rdata, err
    );
endinterface

// File: rtl/simmem_port.sv
// Single-port simulation memory with programmable wait states, active-low byte lanes,
// an out-of-range error flag and a memory-mapped exit register.
module simmem_port #(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter int unsigned       WAIT_CYC   = 0,
    parameter logic [ADDR_W-1:0] EXIT_ADDR  = ADDR_W'(16'hFFFE)
) (
    input  logic              clk,
    input  logic              reset,
    simmem_port_if.slave      bus,
    output logic              exitFlag,
    output logic [DATA_W-1:0] exitCode,
    output logic [31:0]       rdCount,
    output logic [31:0]       wrCount
);
    localparam int unsigned       LANES     = DATA_W / 8;
    localparam int unsigned       LB        = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int unsigned       WORDS     = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << LB) - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic              nrw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LANES-1:0]  nbe_q;

    logic [DATA_W-1:0] ram [WORDS];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  is_exit;
    logic                  oor;
    logic [DATA_W-1:0]     lane_mask;
    logic [DATA_W-1:0]     exit_view;

    always_comb begin
        idx       = addr_q[LB +: DEPTH_LOG2];
        is_exit   = (addr_q & ~LANE_MASK) == (EXIT_ADDR & ~LANE_MASK);
        // a shift past the top bit yields zero, so a full-width array is never out of range
        oor       = !is_exit && ((addr_q >> (LB + DEPTH_LOG2)) != '0);
        lane_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mask[8*i +: 8] = {8{~nbe_q[i]}};
        end
        exit_view = {exitCode[DATA_W-1:1], exitFlag};
    end

    // ram survives reset; a reset in the ACC cycle suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACC && nrw_q && !oor && !is_exit) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (!nbe_q[i]) begin
                    ram[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            nrw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            nbe_q     <= '1;
            bus.busy  <= 1'b0;
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            exitFlag  <= 1'b0;
            exitCode  <= '0;
            rdCount   <= '0;
            wrCount   <= '0;
        end else begin
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            case (state)
                S_IDLE: begin
                    bus.busy <= bus.req;
                    if (bus.req) begin
                        nrw_q   <= bus.nRW;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        nbe_q   <= bus.nBE;
                        cnt     <= 8'(WAIT_CYC);
                        state   <= (WAIT_CYC > 0) ? S_WAIT : S_ACC;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    // busy is left high so it drops together with ack
                    bus.ack <= 1'b1;
                    bus.err <= oor;
                    state   <= S_IDLE;
                    if (nrw_q) begin
                        if (is_exit) begin
                            exitFlag <= 1'b1;
                            exitCode <= wdata_q;
                        end
                        if (wrCount != '1) begin
                            wrCount <= wrCount + 32'd1;
                        end
                    end else begin
                        if (oor) begin
                            bus.rdata <= '0;
                        end else if (is_exit) begin
                            bus.rdata <= exit_view & lane_mask;
                        end else begin
                            bus.rdata <= ram[idx] & lane_mask;
                        end
                        if (rdCount != '1) begin
                            rdCount <= rdCount + 32'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simmem_port.sv
// Scoreboard bench: two memories (0 and 3 wait states) fed the same transactions,
// checked against an array-based reference model with expected ack times.
module tb_simmem_port;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3;
    logic        ef0, ef3;
    logic [15:0] ec0, ec3;
    logic [31:0] rc0, wc0, rc3, wc3;

    simmem_port_if #(.DATA_W(16), .ADDR_W(16)) b0 ();
    simmem_port_if #(.DATA_W(16), .ADDR_W(16)) b3 ();

    simmem_port #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYC(0), .EXIT_ADDR(16'hFFFE)) u0 (
        .clk(clk), .reset(rst0), .bus(b0.slave),
        .exitFlag(ef0), .exitCode(ec0), .rdCount(rc0), .wrCount(wc0)
    );
    simmem_port #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYC(3), .EXIT_ADDR(16'hFFFE)) u3 (
        .clk(clk), .reset(rst3), .bus(b3.slave),
        .exitFlag(ef3), .exitCode(ec3), .rdCount(rc3), .wrCount(wc3)
    );

    typedef struct {
        int          d;
        int          acc_edge;
        int          ack_edge;
        bit          rd;
        bit          err;
        logic [15:0] rdata;
        logic [31:0] rc;
        logic [31:0] wc;
        bit          exf;
        logic [15:0] exc;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mem [2][1024];
    bit          mexf [2];
    logic [15:0] mexc [2];
    logic [31:0] mrc [2];
    logic [31:0] mwc [2];

    int ncmp = 0;
    int nfail = 0;
    int edges = 0;
    bit mon_on = 0;
    bit busy_off3 = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s wait%0d @edge %0d: got %h expected %h", name, (d == 0) ? 0 : 3, edges, act, exp);
        end
    endfunction

    // Reference model: applies the access to the arrays at issue time and records the response.
    function automatic void model_push(int d, bit wr, logic [15:0] a, logic [15:0] wd, logic [1:0] nbe);
        exp_t        e;
        logic [15:0] m;
        bit          ex, oor;
        int          idx;
        m = '0;
        for (int i = 0; i < 2; i++) if (!nbe[i]) m[8*i +: 8] = 8'hFF;
        ex  = (a[15:1] == 15'h7FFF);
        oor = !ex && (a >= 16'h0800);
        idx = int'(a[10:1]);
        e.rdata = '0;
        if (wr) begin
            if (ex) begin
                mexf[d] = 1'b1;
                mexc[d] = wd;
            end else if (!oor) begin
                mem[d][idx] = (mem[d][idx] & ~m) | (wd & m);
            end
            if (mwc[d] != 32'hFFFF_FFFF) mwc[d] = mwc[d] + 1;
        end else begin
            if (ex) e.rdata = {mexc[d][15:1], mexf[d]} & m;
            else if (!oor) e.rdata = mem[d][idx] & m;
            if (mrc[d] != 32'hFFFF_FFFF) mrc[d] = mrc[d] + 1;
        end
        e.d        = d;
        e.rd       = !wr;
        e.err      = oor;
        e.rc       = mrc[d];
        e.wc       = mwc[d];
        e.exf      = mexf[d];
        e.exc      = mexc[d];
        e.acc_edge = edges + 1;
        e.ack_edge = edges + 2 + ((d == 0) ? 0 : 3);
        sbq.push_back(e);
    endfunction

    function automatic void mon(int d, logic ack, logic busy, logic err, logic [15:0] rd,
                                logic exf, logic [15:0] exc, logic [31:0] rc, logic [31:0] wc);
        int k = -1;
        bit eb = 0;
        foreach (sbq[i]) if (k < 0 && sbq[i].d == d) k = i;
        if (k >= 0) eb = (sbq[k].acc_edge <= edges) && (edges <= sbq[k].ack_edge);
        if (!(d == 1 && busy_off3)) chk("busy", d, 32'(busy), 32'(eb));
        if (k >= 0 && edges == sbq[k].ack_edge) begin
            chk("ack", d, 32'(ack), 32'd1);
            if (ack) begin
                chk("err", d, 32'(err), 32'(sbq[k].err));
                if (sbq[k].rd) chk("rdata", d, 32'(rd), 32'(sbq[k].rdata));
                chk("rdCount", d, rc, sbq[k].rc);
                chk("wrCount", d, wc, sbq[k].wc);
                chk("exitFlag", d, 32'(exf), 32'(sbq[k].exf));
                chk("exitCode", d, 32'(exc), 32'(sbq[k].exc));
            end
            sbq.delete(k);
        end else begin
            chk("ack_idle", d, 32'(ack), 32'd0);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, b0.ack, b0.busy, b0.err, b0.rdata, ef0, ec0, rc0, wc0);
            mon(1, b3.ack, b3.busy, b3.err, b3.rdata, ef3, ec3, rc3, wc3);
        end
    end

    function automatic void chk_zero(int d, logic ack, logic busy, logic err, logic [15:0] rd,
                                     logic exf, logic [15:0] exc, logic [31:0] rc, logic [31:0] wc);
        chk("rst_ack", d, 32'(ack), 32'd0);
        chk("rst_busy", d, 32'(busy), 32'd0);
        chk("rst_err", d, 32'(err), 32'd0);
        chk("rst_rdata", d, 32'(rd), 32'd0);
        chk("rst_exitFlag", d, 32'(exf), 32'd0);
        chk("rst_exitCode", d, 32'(exc), 32'd0);
        chk("rst_rdCount", d, rc, 32'd0);
        chk("rst_wrCount", d, wc, 32'd0);
    endfunction

    task automatic scramble();
        logic        w;
        logic [15:0] a, wd;
        logic [1:0]  n;
        w = 1'($urandom); a = 16'($urandom); wd = 16'($urandom); n = 2'($urandom);
        b0.nRW = w; b0.addr = a; b0.wdata = wd; b0.nBE = n;
        b3.nRW = w; b3.addr = a; b3.wdata = wd; b3.nBE = n;
    endtask

    // Called at a negedge; presents one request for a single cycle, then scrambles the bus.
    task automatic drive(input bit to0, input bit to3, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] nbe, input int gap);
        b0.nRW = wr; b0.addr = a; b0.wdata = wd; b0.nBE = nbe; b0.req = to0;
        b3.nRW = wr; b3.addr = a; b3.wdata = wd; b3.nBE = nbe; b3.req = to3;
        if (to0) model_push(0, wr, a, wd, nbe);
        if (to3) model_push(1, wr, a, wd, nbe);
        @(negedge clk);
        b0.req = 1'b0;
        b3.req = 1'b0;
        scramble();
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic both(input bit wr, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] nbe);
        drive(1'b1, 1'b1, wr, a, wd, nbe, 5 + int'($urandom_range(0, 2)));
    endtask

    initial begin
        logic [15:0] a;
        int          r;
        b0.req = 0; b0.nRW = 0; b0.addr = '0; b0.wdata = '0; b0.nBE = '0;
        b3.req = 0; b3.nRW = 0; b3.addr = '0; b3.wdata = '0; b3.nBE = '0;
        for (int d = 0; d < 2; d++) begin
            mexf[d] = 0; mexc[d] = '0; mrc[d] = '0; mwc[d] = '0;
        end
        rst0 = 1; rst3 = 1;
        repeat (3) @(negedge clk);
        chk_zero(0, b0.ack, b0.busy, b0.err, b0.rdata, ef0, ec0, rc0, wc0);
        chk_zero(1, b3.ack, b3.busy, b3.err, b3.rdata, ef3, ec3, rc3, wc3);
        rst0 = 0; rst3 = 0;
        mon_on = 1;

        // basic write/read, byte lanes, out of range, exit register
        both(1, 16'h0010, 16'hA5C3, 2'b00);
        both(0, 16'h0010, 16'h0000, 2'b00);
        both(1, 16'h0000, 16'h5A5A, 2'b00);
        both(1, 16'h0020, 16'h1234, 2'b00);
        both(1, 16'h0020, 16'hABCD, 2'b10);
        both(0, 16'h0020, 16'h0000, 2'b00);
        both(1, 16'h0021, 16'hFFFF, 2'b11);
        both(0, 16'h0020, 16'h0000, 2'b00);
        both(1, 16'h0800, 16'hDEAD, 2'b00);
        both(0, 16'h0000, 16'h0000, 2'b00);
        both(0, 16'h0800, 16'h0000, 2'b00);
        both(1, 16'hFFFE, 16'h0042, 2'b01);
        both(0, 16'hFFFE, 16'h0000, 2'b00);
        both(0, 16'hFFFF, 16'h0000, 2'b10);

        for (int i = 0; i < 16; i++) both(1, 16'h0100 + 16'(2 * i), 16'($urandom), 2'b00);
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 6) a = 16'h0100 + 16'(2 * $urandom_range(0, 15)) + 16'($urandom_range(0, 1));
            else if (r == 7) begin
                case ($urandom_range(0, 2))
                    0:       a = 16'h0000;
                    1:       a = 16'h0010;
                    default: a = 16'h0021;
                endcase
            end else if (r == 8) begin
                a = 16'($urandom) | 16'h0800;
                if (a[15:1] == 15'h7FFF) a = 16'h0800;
            end else a = 16'hFFFE + 16'($urandom_range(0, 1));
            both(1'($urandom), a, 16'($urandom), 2'($urandom));
        end

        // req held high on the 3-wait memory; bus changes during WAIT must be ignored
        for (int k = 0; k < 2; k++) begin
            a = 16'h0100 + 16'(4 * k);
            b3.req = 1; b3.nRW = 0; b3.addr = a; b3.nBE = 2'b00;
            model_push(1, 1'b0, a, 16'h0000, 2'b00);
            @(negedge clk);
            b3.nRW = 1; b3.addr = 16'h0100 + 16'(2 * $urandom_range(0, 15));
            b3.wdata = 16'($urandom); b3.nBE = 2'b00;
            repeat (4) @(negedge clk);
        end
        b3.req = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) both(0, 16'h0100 + 16'(2 * i), 16'h0000, 2'b00);

        // reset during the second WAIT cycle of a write abandons it
        busy_off3 = 1;
        b3.nRW = 1; b3.addr = 16'h0010; b3.wdata = 16'hBEEF; b3.nBE = 2'b00; b3.req = 1;
        @(negedge clk);
        b3.req = 0;
        @(negedge clk);
        rst3 = 1;
        @(negedge clk);
        chk_zero(1, b3.ack, b3.busy, b3.err, b3.rdata, ef3, ec3, rc3, wc3);
        rst3 = 0;
        mexf[1] = 0; mexc[1] = '0; mrc[1] = '0; mwc[1] = '0;
        @(negedge clk);
        busy_off3 = 0;
        repeat (5) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 7);
        drive(1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 2'b00, 7);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
